mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM-stage load/store unit of the five-stage pipeline, between the EX/MEM pipeline register and the MEM/WB pipeline register. Issues loads and stores to the data memory over a req/ack handshake, and stalls upstream until the access completes. Aligns and sign-/zero-extends load data, and presents one registered writeback result per retired instruction to MEM/WB. Detects misaligned accesses and memory timeouts.

## Interface
- TIMEOUT, 15: maximum BUSY cycles waiting for dm_ack before a bus error (1..255).
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- mem_valid_in  in  1  instruction present in MEM.
- mem_load_in / mem_store_in  in  1 each  instruction is a load / store.
- mem_size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_unsigned_in  in  1  zero-extend load (LBU/LHU).
- mem_addr_in  in  32  effective address from the ALU.
- mem_store_data_in  in  32  rt value for stores.
- alu_result_in  in  32  result for non-memory instructions.
- mem_rd_in  in  5  destination register.
- mem_rf_enable_in  in  1  instruction writes the register file.
- dm_req / dm_we  out  1 each  memory request / write strobe.
- dm_addr  out  32  word address ({addr[31:2],2'b00}).
- dm_be  out  4  byte enables, big-endian (be[3] = byte offset 0 = bits 31:24).
- dm_wdata  out  32  replicated store data.
- dm_rdata  in  32  read data, valid with dm_ack.
- dm_ack  in  1  one-cycle completion pulse.
- stall  out  1  combinational; upstream holds all *_in while high.
- wb_valid, wb_rf_enable  out  1 each; wb_rd  out  5; wb_data  out  32  registered result to MEM/WB.
- addr_error, bus_error  out  1 each  registered one-cycle fault pulses.

## Operation
- States: IDLE, BUSY. Reset: state IDLE, dm_req/dm_we 0, dm_addr/dm_wdata 0, dm_be 0, wb_* 0, addr_error/bus_error 0, wait counter 0.
- Memory op = mem_valid_in & (mem_load_in ^ mem_store_in). Misaligned = half with addr[0]=1, word with addr[1:0]≠0, or load&store both set.
- IDLE, aligned memory op: latch op, size, unsigned, offset, rd, rf_enable. Drive dm_addr, dm_be, dm_wdata, dm_we=store, dm_req=1 (registered). Go BUSY. stall=1 this cycle.
- IDLE, misaligned: no access. No stall. Next edge: addr_error=1, wb_valid=1, wb_rf_enable=0.
- IDLE, non-memory or mem_valid_in=0: next edge, wb_valid=mem_valid_in, wb_data=alu_result_in, wb_rd, wb_rf_enable pass through.
- BUSY: stall = !dm_ack. dm_req is held with all dm_* stable. The counter increments each cycle without ack.
- dm_ack in BUSY: drop dm_req, return to IDLE. Next edge: wb_valid=1, wb_rd latched. For loads, wb_rf_enable = latched rf_enable and wb_data = extracted load data. For stores, wb_rf_enable=0.
- Counter reaching TIMEOUT in BUSY without ack: drop dm_req, go IDLE, bus_error=1 pulse, wb_valid=1, wb_rf_enable=0. The stall releases that cycle.
- Byte enables: byte at offset k → be bit 3-k. Half at offset 0 → 1100, offset 2 → 0011. Word → 1111.
- Store data: byte {4{sd[7:0]}}, half {2{sd[15:0]}}, word sd.
- Load extract: byte k → rdata[31-8k -: 8], half offset 0 → rdata[31:16], offset 2 → rdata[15:0]. Sign-extend unless mem_unsigned_in.
- While stalled, wb_valid=0 each cycle (bubble into MEM/WB).
- dm_ack in IDLE: ignored, including a late ack after reset or timeout.
- Reset mid-BUSY: dm_req drops asynchronously. No wb result for the aborted op.

## Timing
- Non-memory instruction: 1 cycle to wb_*.
- Memory op: accept cycle, then N≥1 BUSY cycles; wb_* is valid at the edge ending the ack cycle. Minimum 2 cycles with ack on the first BUSY cycle.
- stall goes low combinationally in the ack cycle. Upstream advances at the same edge wb_* updates. There is no bubble between back-to-back memory ops.
- Faults: addr_error 1 cycle after presentation. bus_error at the edge where the counter reaches TIMEOUT.

## Test plan
- Reset then ADD: alu_result_in=0x0000_1234, rd=5, rf_en=1 → next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, stall never high.
- LB at 0x1001, signed, memory ack after 3 BUSY cycles with rdata=0x11_F2_33_44 → dm_be=0100, dm_addr=0x1000; stall high 4 cycles; wb_data=0xFFFF_FFF2. Repeat as LBU → 0x0000_00F2.
- SH at 0x2002, sd=0xABCD_5678 → dm_we=1, dm_be=0011, dm_wdata=0x5678_5678; wb_rf_enable=0 after ack.
- LW at 0x3001 → no dm_req, addr_error pulse, wb_valid=1, wb_rf_enable=0, stall 0.
- LW with no ack and TIMEOUT=4 → dm_req high 4 cycles, bus_error pulse, stall drops. A late ack 2 cycles later produces no wb_valid.
- Back-to-back SW then LW, each with an immediate ack → both retire 2 cycles apart. Separately, assert reset during BUSY → dm_req=0 immediately and all outputs at reset values.

Source files
------------

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage_if
// Purpose  : Data-memory req/ack bus between the MEM stage and data memory.
// Revision : 1.0
// ============================================================================
interface mem_access_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_rdata, dm_ack
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_rdata, dm_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : MEM-stage load/store unit: req/ack data-memory access, load
//            alignment/extension, misalignment and timeout fault reporting.
// Revision : 1.0
// ============================================================================
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_valid_in,
  input  logic               mem_load_in,
  input  logic               mem_store_in,
  input  logic [1:0]         mem_size_in,
  input  logic               mem_unsigned_in,
  input  logic [31:0]        mem_addr_in,
  input  logic [31:0]        mem_store_data_in,
  input  logic [31:0]        alu_result_in,
  input  logic [4:0]         mem_rd_in,
  input  logic               mem_rf_enable_in,
  mem_access_stage_if.master dm,
  output logic               stall,
  output logic               wb_valid,
  output logic               wb_rf_enable,
  output logic [4:0]         wb_rd,
  output logic [31:0]        wb_data,
  output logic               addr_error,
  output logic               bus_error
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [7:0] c_last_wait = 8'(TIMEOUT - 1);

  logic [0:0]  r_state;
  logic [0:0]  w_next_state;

  logic        r_dm_req;
  logic        r_dm_we;
  logic [31:0] r_dm_addr;
  logic [3:0]  r_dm_be;
  logic [31:0] r_dm_wdata;

  logic        r_is_load;
  logic [1:0]  r_size;
  logic [1:0]  r_offset;
  logic        r_unsigned;
  logic [4:0]  r_rd;
  logic        r_rf_enable;
  logic [7:0]  r_wait_cnt;

  logic        w_is_half;
  logic        w_is_word;
  logic        w_mem_op;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_ack;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_is_half = (mem_size_in == 2'b01);
  assign w_is_word = mem_size_in[1];
  assign w_mem_op  = mem_valid_in & (mem_load_in ^ mem_store_in);

  // Load+store together is malformed and reported like a misaligned access.
  assign w_misaligned = mem_valid_in &
                        ((mem_load_in & mem_store_in) |
                         (w_mem_op & ((w_is_half & mem_addr_in[0]) |
                                      (w_is_word & (mem_addr_in[1:0] != 2'b00)))));

  assign w_accept  = (r_state == S_IDLE) & w_mem_op & ~w_misaligned;
  assign w_ack     = (r_state == S_BUSY) & dm.dm_ack;
  assign w_timeout = (r_state == S_BUSY) & ~dm.dm_ack & (r_wait_cnt == c_last_wait);

  assign dm.dm_req   = r_dm_req;
  assign dm.dm_we    = r_dm_we;
  assign dm.dm_addr  = r_dm_addr;
  assign dm.dm_be    = r_dm_be;
  assign dm.dm_wdata = r_dm_wdata;

  // Big-endian lanes: byte offset 0 lives in bits 31:24.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_store_data_in;
    if (w_is_word) begin
      w_be    = 4'b1111;
      w_wdata = mem_store_data_in;
    end else if (w_is_half) begin
      w_be    = mem_addr_in[1] ? 4'b0011 : 4'b1100;
      w_wdata = {2{mem_store_data_in[15:0]}};
    end else begin
      w_be    = 4'b1000 >> mem_addr_in[1:0];
      w_wdata = {4{mem_store_data_in[7:0]}};
    end
  end

  always_comb begin
    w_byte = dm.dm_rdata[31:24];
    case (r_offset)
      2'b01:   w_byte = dm.dm_rdata[23:16];
      2'b10:   w_byte = dm.dm_rdata[15:8];
      2'b11:   w_byte = dm.dm_rdata[7:0];
      default: w_byte = dm.dm_rdata[31:24];
    endcase
    w_half = r_offset[1] ? dm.dm_rdata[15:0] : dm.dm_rdata[31:16];
    if (r_size[1]) begin
      w_load_data = dm.dm_rdata;
    end else if (r_size[0]) begin
      w_load_data = {{16{~r_unsigned & w_half[15]}}, w_half};
    end else begin
      w_load_data = {{24{~r_unsigned & w_byte[7]}}, w_byte};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_BUSY;
      S_BUSY:  if (w_ack || w_timeout) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (r_state)
      S_IDLE:  stall = w_accept;
      S_BUSY:  stall = ~dm.dm_ack & ~w_timeout;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dm_req     <= 1'b0;
      r_dm_we      <= 1'b0;
      r_dm_addr    <= 32'd0;
      r_dm_be      <= 4'd0;
      r_dm_wdata   <= 32'd0;
      r_is_load    <= 1'b0;
      r_size       <= 2'd0;
      r_offset     <= 2'd0;
      r_unsigned   <= 1'b0;
      r_rd         <= 5'd0;
      r_rf_enable  <= 1'b0;
      r_wait_cnt   <= 8'd0;
      wb_valid     <= 1'b0;
      wb_rf_enable <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      addr_error   <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      addr_error <= 1'b0;
      bus_error  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          r_is_load    <= mem_load_in;
          r_size       <= mem_size_in;
          r_offset     <= mem_addr_in[1:0];
          r_unsigned   <= mem_unsigned_in;
          r_rd         <= mem_rd_in;
          r_rf_enable  <= mem_rf_enable_in;
          r_wait_cnt   <= 8'd0;
          r_dm_req     <= 1'b1;
          r_dm_we      <= mem_store_in;
          r_dm_addr    <= {mem_addr_in[31:2], 2'b00};
          r_dm_be      <= w_be;
          r_dm_wdata   <= w_wdata;
          wb_valid     <= 1'b0;
          wb_rf_enable <= 1'b0;
        end else if (w_misaligned) begin
          addr_error   <= 1'b1;
          wb_valid     <= 1'b1;
          wb_rf_enable <= 1'b0;
          wb_rd        <= mem_rd_in;
          wb_data      <= alu_result_in;
        end else begin
          wb_valid     <= mem_valid_in;
          wb_rf_enable <= mem_rf_enable_in;
          wb_rd        <= mem_rd_in;
          wb_data      <= alu_result_in;
        end
      end else begin
        if (w_ack) begin
          r_dm_req     <= 1'b0;
          wb_valid     <= 1'b1;
          wb_rd        <= r_rd;
          wb_rf_enable <= r_is_load & r_rf_enable;
          wb_data      <= r_is_load ? w_load_data : 32'd0;
        end else if (w_timeout) begin
          r_dm_req     <= 1'b0;
          bus_error    <= 1'b1;
          wb_valid     <= 1'b1;
          wb_rf_enable <= 1'b0;
          wb_rd        <= r_rd;
          wb_data      <= 32'd0;
        end else begin
          r_wait_cnt   <= r_wait_cnt + 8'd1;
          wb_valid     <= 1'b0;
          wb_rf_enable <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Directed and randomized self-checking bench for mem_access_stage.
// Revision : 1.0
// ============================================================================
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        mem_valid_in;
  logic        mem_load_in;
  logic        mem_store_in;
  logic [1:0]  mem_size_in;
  logic        mem_unsigned_in;
  logic [31:0] mem_addr_in;
  logic [31:0] mem_store_data_in;
  logic [31:0] alu_result_in;
  logic [4:0]  mem_rd_in;
  logic        mem_rf_enable_in;
  logic        stall;
  logic        wb_valid;
  logic        wb_rf_enable;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        addr_error;
  logic        bus_error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_retire = 0;

  mem_access_stage_if dm_bus ();

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .mem_valid_in      (mem_valid_in),
    .mem_load_in       (mem_load_in),
    .mem_store_in      (mem_store_in),
    .mem_size_in       (mem_size_in),
    .mem_unsigned_in   (mem_unsigned_in),
    .mem_addr_in       (mem_addr_in),
    .mem_store_data_in (mem_store_data_in),
    .alu_result_in     (alu_result_in),
    .mem_rd_in         (mem_rd_in),
    .mem_rf_enable_in  (mem_rf_enable_in),
    .dm                (dm_bus.master),
    .stall             (stall),
    .wb_valid          (wb_valid),
    .wb_rf_enable      (wb_rf_enable),
    .wb_rd             (wb_rd),
    .wb_data           (wb_data),
    .addr_error        (addr_error),
    .bus_error         (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference rules written as byte arithmetic rather than lane muxes.
  function automatic int f_nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] sz, input logic [31:0] addr);
    int n = f_nbytes(sz);
    int off = int'(addr % 4);
    logic [3:0] be = 4'd0;
    for (int k = off; k < off + n; k++) be[3-k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] sd);
    int n = f_nbytes(sz);
    logic [63:0] mask = (64'd1 << (8*n)) - 64'd1;
    logic [63:0] res = 64'd0;
    for (int i = 0; i < 4 / n; i++) res = res | (({32'd0, sd} & mask) << (8*n*i));
    return res[31:0];
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] sz, input bit uns,
                                         input logic [31:0] addr, input logic [31:0] rdata);
    int n = f_nbytes(sz);
    int off = int'(addr % 4);
    logic [63:0] mask = (64'd1 << (8*n)) - 64'd1;
    logic [63:0] val = ({32'd0, rdata} >> (8*(4 - off - n))) & mask;
    if (!uns && n < 4 && val[8*n-1]) val = val | ~mask;
    return val[31:0];
  endfunction

  task automatic do_alu(input bit v, input logic [31:0] res, input logic [4:0] rd, input bit rfen);
    mem_valid_in      = v;
    mem_load_in       = 1'b0;
    mem_store_in      = 1'b0;
    mem_size_in       = 2'($urandom_range(0, 3));
    mem_addr_in       = $urandom();
    alu_result_in     = res;
    mem_rd_in         = rd;
    mem_rf_enable_in  = rfen;
    #1;
    chk("alu_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("alu_wb_valid", 32'(wb_valid), 32'(v));
    if (v) begin
      chk("alu_wb_data", wb_data, res);
      chk("alu_wb_rd", 32'(wb_rd), 32'(rd));
      chk("alu_wb_rf_en", 32'(wb_rf_enable), 32'(rfen));
    end
    chk("alu_addr_error", 32'(addr_error), 32'd0);
    chk("alu_dm_req", 32'(dm_bus.dm_req), 32'd0);
    mem_valid_in = 1'b0;
  endtask

  task automatic do_mem(input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [4:0] rd, input bit rfen, input int delay,
                        input logic [31:0] rdata, output int stalls, output int reqs);
    int n;
    bit mis;
    bit acked;
    n      = f_nbytes(sz);
    mis    = (ld && st) || (addr % n != 0);
    stalls = 0;
    reqs   = 0;
    acked  = 1'b0;
    mem_valid_in      = 1'b1;
    mem_load_in       = ld;
    mem_store_in      = st;
    mem_size_in       = sz;
    mem_unsigned_in   = uns;
    mem_addr_in       = addr;
    mem_store_data_in = sd;
    alu_result_in     = $urandom();
    mem_rd_in         = rd;
    mem_rf_enable_in  = rfen;
    #1;
    if (mis) begin
      chk("mis_stall", 32'(stall), 32'd0);
      @(negedge clk);
      chk("mis_addr_error", 32'(addr_error), 32'd1);
      chk("mis_wb_valid", 32'(wb_valid), 32'd1);
      chk("mis_wb_rf_en", 32'(wb_rf_enable), 32'd0);
      chk("mis_dm_req", 32'(dm_bus.dm_req), 32'd0);
      mem_valid_in = 1'b0;
      return;
    end
    chk("acc_stall", 32'(stall), 32'd1);
    stalls++;
    @(negedge clk);
    chk("acc_dm_req", 32'(dm_bus.dm_req), 32'd1);
    chk("acc_dm_we", 32'(dm_bus.dm_we), 32'(st));
    chk("acc_dm_addr", dm_bus.dm_addr, addr - (addr % 4));
    chk("acc_dm_be", 32'(dm_bus.dm_be), 32'(f_be(sz, addr)));
    if (st) chk("acc_dm_wdata", dm_bus.dm_wdata, f_wdata(sz, sd));
    for (int c = 0; c < TO; c++) begin
      if (c == delay) begin
        dm_bus.dm_ack   = 1'b1;
        dm_bus.dm_rdata = rdata;
        #1;
        chk("ack_stall", 32'(stall), 32'd0);
        @(negedge clk);
        dm_bus.dm_ack = 1'b0;
        acked = 1'b1;
        break;
      end
      chk("busy_dm_req", 32'(dm_bus.dm_req), 32'd1);
      chk("busy_dm_addr", dm_bus.dm_addr, addr - (addr % 4));
      chk("busy_wb_valid", 32'(wb_valid), 32'd0);
      reqs++;
      if (c == TO - 1) begin
        chk("timeout_stall", 32'(stall), 32'd0);
      end else begin
        chk("busy_stall", 32'(stall), 32'd1);
        stalls++;
      end
      @(negedge clk);
    end
    if (acked) begin
      chk("ret_wb_valid", 32'(wb_valid), 32'd1);
      chk("ret_wb_rd", 32'(wb_rd), 32'(rd));
      chk("ret_wb_rf_en", 32'(wb_rf_enable), 32'(ld && rfen));
      if (ld) chk("ret_wb_data", wb_data, f_load(sz, uns, addr, rdata));
      chk("ret_bus_error", 32'(bus_error), 32'd0);
    end else begin
      chk("to_bus_error", 32'(bus_error), 32'd1);
      chk("to_wb_valid", 32'(wb_valid), 32'd1);
      chk("to_wb_rf_en", 32'(wb_rf_enable), 32'd0);
      chk("to_dm_req", 32'(dm_bus.dm_req), 32'd0);
    end
    last_retire  = cyc;
    mem_valid_in = 1'b0;
  endtask

  initial begin
    int stalls;
    int reqs;
    int t_first;
    reset             = 1'b1;
    mem_valid_in      = 1'b0;
    mem_load_in       = 1'b0;
    mem_store_in      = 1'b0;
    mem_size_in       = 2'b00;
    mem_unsigned_in   = 1'b0;
    mem_addr_in       = 32'd0;
    mem_store_data_in = 32'd0;
    alu_result_in     = 32'd0;
    mem_rd_in         = 5'd0;
    mem_rf_enable_in  = 1'b0;
    dm_bus.dm_ack     = 1'b0;
    dm_bus.dm_rdata   = 32'd0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_rf_en", 32'(wb_rf_enable), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_dm_req", 32'(dm_bus.dm_req), 32'd0);
    chk("rst_dm_we", 32'(dm_bus.dm_we), 32'd0);
    chk("rst_dm_addr", dm_bus.dm_addr, 32'd0);
    chk("rst_dm_be", 32'(dm_bus.dm_be), 32'd0);
    chk("rst_dm_wdata", dm_bus.dm_wdata, 32'd0);
    chk("rst_addr_error", 32'(addr_error), 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    reset = 1'b0;

    do_alu(1'b1, 32'h0000_1234, 5'd5, 1'b1);

    do_mem(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'd0, 5'd3, 1'b1, 3, 32'h11F2_3344, stalls, reqs);
    chk("lb_stall_cycles", 32'(stalls), 32'd4);
    do_mem(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1001, 32'd0, 5'd4, 1'b1, 3, 32'h11F2_3344, stalls, reqs);
    chk("lbu_stall_cycles", 32'(stalls), 32'd4);

    do_mem(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'hABCD_5678, 5'd0, 1'b0, 1, 32'd0, stalls, reqs);
    do_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'd0, 5'd6, 1'b1, 0, 32'd0, stalls, reqs);

    do_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3004, 32'd0, 5'd6, 1'b1, 99, 32'd0, stalls, reqs);
    chk("to_req_cycles", 32'(reqs), 32'(TO));
    @(negedge clk);
    dm_bus.dm_ack   = 1'b1;
    dm_bus.dm_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dm_bus.dm_ack = 1'b0;
    chk("late_ack_wb_valid", 32'(wb_valid), 32'd0);
    chk("late_ack_dm_req", 32'(dm_bus.dm_req), 32'd0);
    do_alu(1'b1, 32'h0BAD_F00D, 5'd9, 1'b1);

    do_mem(1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_5000, 32'h1357_9BDF, 5'd0, 1'b0, 0, 32'd0, stalls, reqs);
    t_first = last_retire;
    do_mem(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'd0, 5'd8, 1'b1, 0, 32'h1357_9BDF, stalls, reqs);
    chk("b2b_retire_gap", 32'(last_retire - t_first), 32'd2);

    mem_valid_in     = 1'b1;
    mem_load_in      = 1'b1;
    mem_store_in     = 1'b0;
    mem_size_in      = 2'b10;
    mem_addr_in      = 32'h0000_4000;
    mem_rd_in        = 5'd7;
    mem_rf_enable_in = 1'b1;
    @(negedge clk);
    chk("rst_busy_pre_req", 32'(dm_bus.dm_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_busy_dm_req", 32'(dm_bus.dm_req), 32'd0);
    chk("rst_busy_dm_be", 32'(dm_bus.dm_be), 32'd0);
    chk("rst_busy_dm_addr", dm_bus.dm_addr, 32'd0);
    chk("rst_busy_wb_valid", 32'(wb_valid), 32'd0);
    mem_valid_in = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    dm_bus.dm_ack = 1'b1;
    @(negedge clk);
    dm_bus.dm_ack = 1'b0;
    chk("rst_busy_no_wb", 32'(wb_valid), 32'd0);

    for (int i = 0; i < 60; i++) begin
      int kind;
      bit ld;
      bit st;
      kind = int'($urandom_range(0, 4));
      if (kind == 0) begin
        do_alu(1'($urandom_range(0, 1)), $urandom(), 5'($urandom()), 1'($urandom_range(0, 1)));
      end else begin
        ld = (kind == 1 || kind == 3);
        st = (kind == 2 || kind == 3);
        if (kind == 4) begin
          ld = 1'($urandom_range(0, 1));
          st = ~ld;
        end
        if (kind == 3 && $urandom_range(0, 1) == 0) st = 1'b0;
        do_mem(ld, st, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom(), $urandom(),
               5'($urandom()), 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), $urandom(),
               stalls, reqs);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
